// File: rtl/tft_fifo_resp_pkg.sv
// Shared definitions for the TFT display-data responder.
// Contents:
//   TFT_IDX_W    - width of a linear frame byte index
//   TFT_LAST_IDX - last linear byte index of a frame (index wraps to 0 after it)
//   fetch_st_e   - VRAM prefetch FSM states
//   tft_idx_inc  - index increment modulo (last_idx + 1)
package lcdc_tft_pkg;

   localparam int unsigned TFT_IDX_W = 13;
   localparam logic [TFT_IDX_W-1:0] TFT_LAST_IDX = 13'h12bf;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StData
   } fetch_st_e;

   function automatic logic [TFT_IDX_W-1:0] tft_idx_inc(input logic [TFT_IDX_W-1:0] idx,
                                                        input logic [TFT_IDX_W-1:0] last_idx);
      return (idx == last_idx) ? '0 : idx + TFT_IDX_W'(1);
   endfunction

endpackage

// File: rtl/tft_fifo_resp_if.sv
// Display-data read port between the TFT timing generator and the responder.
// Signals:
//   fifo_rdreq - one-cycle read request (timing generator -> responder)
//   fifo_raddr - linear byte index requested
//   fifo_rdack - same-cycle acknowledge (responder -> timing generator)
//   fifo_rdata - read data, registered, valid the cycle after an acknowledge
// Modports: master = timing generator, slave = responder.
interface tft_fifo_resp_if;
   import lcdc_tft_pkg::*;

   logic                 fifo_rdreq;
   logic [TFT_IDX_W-1:0] fifo_raddr;
   logic                 fifo_rdack;
   logic [7:0]           fifo_rdata;

   modport master (
      output fifo_rdreq,
      output fifo_raddr,
      input  fifo_rdack,
      input  fifo_rdata
   );

   modport slave (
      input  fifo_rdreq,
      input  fifo_raddr,
      output fifo_rdack,
      output fifo_rdata
   );

endinterface

// File: rtl/tft_fifo_resp_pf_fifo.sv
// tft_pf_fifo: synchronous DEPTH x 8 prefetch FIFO.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   push_i     - write data_i at the tail (ignored when full)
//   data_i     - write data
//   pop_i      - drop the head entry (ignored when empty)
//   flush_i    - empty the FIFO; has priority over push and pop
//   head_o     - current head entry (combinational)
//   count_o    - number of stored entries
//   empty_o    - count_o == 0
module tft_pf_fifo #(
   parameter int unsigned DEPTH = 8,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [7:0]    data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output logic [7:0]    head_o,
   output logic [CW-1:0] count_o,
   output logic          empty_o
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign do_push = push_i & (count_q != CW'(DEPTH));
   assign do_pop  = pop_i & (count_q != '0);

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/tft_fifo_resp.sv
// tft_fifo_resp: responder for the TFT timing generator's display-data read port.
// Prefetches sequential display bytes from VRAM into a small buffer and answers each
// one-cycle read request in the same cycle.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   reg_sad_i      - screen start address in VRAM
//   tft_vsync_i    - VSYNC (active low); its falling edge restarts the frame at index 0
//   fifo_if        - read port (slave side): rdreq/raddr in, rdack/rdata out
//   vram_req_o     - VRAM fetch request, held with a stable address until vram_ack_i
//   vram_addr_o    - VRAM fetch address = reg_sad_i + prefetch index
//   vram_ack_i     - VRAM grant; vram_rdata_i is valid the following cycle
//   vram_rdata_i   - VRAM read data
//   underrun_o     - sticky: some request was not acknowledged
//   underrun_cnt_o - saturating count of unacknowledged requests
//                    (only with TFT_FIFO_RESP_UNDERRUN_CNT_EN defined)
module tft_fifo_resp
   import lcdc_tft_pkg::*;
#(
   parameter int unsigned          DEPTH    = 8,
   parameter logic [TFT_IDX_W-1:0] LAST_IDX = TFT_LAST_IDX,
   parameter int unsigned          VRAM_AW  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [VRAM_AW-1:0] reg_sad_i,
   input  logic               tft_vsync_i,
   tft_fifo_resp_if.slave     fifo_if,
   output logic               vram_req_o,
   output logic [VRAM_AW-1:0] vram_addr_o,
   input  logic               vram_ack_i,
   input  logic [7:0]         vram_rdata_i,
`ifdef TFT_FIFO_RESP_UNDERRUN_CNT_EN
   output logic [15:0]        underrun_cnt_o,
`endif
   output logic               underrun_o
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_st_e            state_q;
   logic                 vram_req_q;
   logic [VRAM_AW-1:0]   vram_addr_q;
   logic [TFT_IDX_W-1:0] pf_idx_q, exp_idx_q;
   logic                 discard_q;
   logic                 vsync_q;
   logic [7:0]           rdata_q;
   logic                 underrun_q;

   logic                 frame_start, idx_match, hit, miss, flush, nack;
   logic [TFT_IDX_W-1:0] restart_idx;
   logic                 push, can_fetch, empty;
   logic [7:0]           head;
   logic [CW-1:0]        count;

   tft_pf_fifo #(
      .DEPTH (DEPTH)
   ) u_pf_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (vram_rdata_i),
      .pop_i   (hit),
      .flush_i (flush),
      .head_o  (head),
      .count_o (count),
      .empty_o (empty)
   );

   // Frame start is the registered-compare falling edge of VSYNC; it overrides any request.
   assign frame_start = vsync_q & ~tft_vsync_i;
   assign idx_match   = (fifo_if.fifo_raddr == exp_idx_q);
   assign hit         = fifo_if.fifo_rdreq & ~empty & idx_match & ~frame_start;
   assign miss        = fifo_if.fifo_rdreq & ~idx_match & ~frame_start;
   assign flush       = frame_start | miss;
   assign restart_idx = frame_start ? '0 : fifo_if.fifo_raddr;
   assign nack        = fifo_if.fifo_rdreq & ~hit;

   assign push      = (state_q == StData) & ~discard_q;
   assign can_fetch = (count + CW'(state_q != StIdle)) < CW'(DEPTH);

   assign fifo_if.fifo_rdack = hit;
   assign fifo_if.fifo_rdata = rdata_q;
   assign vram_req_o         = vram_req_q;
   assign vram_addr_o        = vram_addr_q;
   assign underrun_o         = underrun_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         vsync_q    <= 1'b1;
         exp_idx_q  <= '0;
         rdata_q    <= 8'h00;
         underrun_q <= 1'b0;
      end else begin
         vsync_q <= tft_vsync_i;
         if (flush) begin
            exp_idx_q <= restart_idx;
         end else if (hit) begin
            exp_idx_q <= tft_idx_inc(exp_idx_q, LAST_IDX);
         end
         if (hit) rdata_q <= head;
         // A request lost to a frame start leaves the sticky flag alone.
         if (nack && !frame_start) underrun_q <= 1'b1;
      end
   end

   // Fetch FSM: one fetch outstanding at most, so count + outstanding never exceeds DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         vram_req_q  <= 1'b0;
         vram_addr_q <= '0;
         pf_idx_q    <= '0;
         discard_q   <= 1'b0;
      end else begin
         if (flush) pf_idx_q <= restart_idx;
         unique case (state_q)
            StIdle: begin
               if (can_fetch && !flush) begin
                  state_q     <= StReq;
                  vram_req_q  <= 1'b1;
                  vram_addr_q <= reg_sad_i + VRAM_AW'(pf_idx_q);
               end
            end
            StReq: begin
               // A flushed fetch still completes its handshake but its byte is dropped.
               if (flush) discard_q <= 1'b1;
               if (vram_ack_i) begin
                  state_q    <= StData;
                  vram_req_q <= 1'b0;
                  if (!flush && !discard_q) pf_idx_q <= tft_idx_inc(pf_idx_q, LAST_IDX);
               end
            end
            StData: begin
               state_q   <= StIdle;
               discard_q <= 1'b0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

`ifdef TFT_FIFO_RESP_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_cnt_q <= '0;
      end else if (nack && underrun_cnt_q != 16'hffff) begin
         underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
   end

   assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_tft_fifo_resp.sv
// Self-checking bench for tft_fifo_resp. Read requests push their expected acknowledge and
// data into a scoreboard queue; a monitor on the falling edge pops and compares. A small
// VRAM model acks every request (when enabled) and logs fetch addresses for direct checks.
module tb_tft_fifo_resp;
   import lcdc_tft_pkg::*;

   typedef struct {
      logic       ack;
      logic [7:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] reg_sad = 16'h0100;
   logic        tft_vsync = 1'b1;
   logic        vram_req;
   logic [15:0] vram_addr;
   logic        vram_ack = 1'b0;
   logic [7:0]  vram_rdata = 8'hee;
   logic        underrun;
`ifdef TFT_FIFO_RESP_UNDERRUN_CNT_EN
   logic [15:0] underrun_cnt;
`endif

   int          total = 0;
   int          bad = 0;
   bit          ack_en = 1'b0;
   logic [15:0] lat_addr = '0;
   logic [15:0] flog[$];
   exp_t        exp_q[$];
   bit          pend = 1'b0;
   logic [7:0]  pend_data = '0;

   tft_fifo_resp_if bus ();

   tft_fifo_resp #(
      .DEPTH    (8),
      .LAST_IDX (13'h12bf),
      .VRAM_AW  (16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .reg_sad_i      (reg_sad),
      .tft_vsync_i    (tft_vsync),
      .fifo_if        (bus),
      .vram_req_o     (vram_req),
      .vram_addr_o    (vram_addr),
      .vram_ack_i     (vram_ack),
      .vram_rdata_i   (vram_rdata),
`ifdef TFT_FIFO_RESP_UNDERRUN_CNT_EN
      .underrun_cnt_o (underrun_cnt),
`endif
      .underrun_o     (underrun)
   );

   always #5 clk = ~clk;

   // VRAM contents: a simple address hash so every byte is checkable.
   function automatic logic [7:0] vbyte(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3c;
   endfunction

   function automatic logic [15:0] vaddr(input logic [15:0] sad, input logic [12:0] idx);
      return sad + {3'b000, idx};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [12:0] idx, input logic ack, input logic [7:0] data);
      exp_q.push_back('{ack: ack, data: data});
      bus.fifo_rdreq = 1'b1;
      bus.fifo_raddr = idx;
      tick(1);
      bus.fifo_rdreq = 1'b0;
   endtask

   task automatic chk_fetch(input int i, input logic [15:0] exp);
      logic [15:0] act;
      act = (flog.size() > i) ? flog[i] : 16'hxxxx;
      chk($sformatf("fetch_addr[%0d]", i), {16'h0, act}, {16'h0, exp});
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdack"}, {31'h0, bus.fifo_rdack}, 32'h0);
      chk({tag, "_rdata"}, {24'h0, bus.fifo_rdata}, 32'h0);
      chk({tag, "_vram_req"}, {31'h0, vram_req}, 32'h0);
      chk({tag, "_vram_addr"}, {16'h0, vram_addr}, 32'h0);
      chk({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
`ifdef TFT_FIFO_RESP_UNDERRUN_CNT_EN
      chk({tag, "_underrun_cnt"}, {16'h0, underrun_cnt}, 32'h0);
`endif
   endtask

   task automatic do_reset(input logic [15:0] sad, input bit ack_on);
      rst       = 1'b1;
      tft_vsync = 1'b1;
      reg_sad   = sad;
      ack_en    = ack_on;
      tick(2);
      rst = 1'b0;
   endtask

   // VRAM model: ack one cycle after seeing a request, data the cycle after the ack.
   initial begin
      forever begin
         @(negedge clk);
         if (vram_ack) vram_rdata = vbyte(lat_addr);
         else vram_rdata = 8'hee;
         vram_ack = ack_en && vram_req && !vram_ack;
         if (vram_ack) begin
            lat_addr = vram_addr;
            flog.push_back(vram_addr);
         end
      end
   end

   // Monitor: rdack checked in the request cycle, rdata one cycle after an acknowledge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("rdata", {24'h0, bus.fifo_rdata}, {24'h0, pend_data});
            pend = 1'b0;
         end
         if (bus.fifo_rdreq) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL sb_unexpected_req: got a request with no expectation at %0t", $time);
            end else begin
               e = exp_q.pop_front();
               chk("rdack", {31'h0, bus.fifo_rdack}, {31'h0, e.ack});
               if (e.ack) begin
                  pend      = 1'b1;
                  pend_data = e.data;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish want finish by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.fifo_rdreq = 1'b0;
      bus.fifo_raddr = '0;

      // Reset state, then fill from 0x0100 and stop at 8 entries.
      tick(2);
      chk_reset("rst1");
      rst    = 1'b0;
      ack_en = 1'b1;
      tick(40);
      chk("fill_cnt", flog.size(), 8);
      for (int i = 0; i < 8; i++) chk_fetch(i, 16'h0100 + 16'(i));

      // VSYNC falling edge: flush, refetch from index 0.
      flog.delete();
      tft_vsync = 1'b0;
      tick(40);
      chk("vsync_fill_cnt", flog.size(), 8);
      chk_fetch(0, 16'h0100);
      chk_fetch(7, 16'h0107);
      for (int i = 0; i < 4; i++) req(13'(i), 1'b1, vbyte(16'h0100 + 16'(i)));
      tick(30);

      // Index and address wrap: restart at LAST_IDX with reg_sad near the top of VRAM.
      reg_sad = 16'hfff0;
      flog.delete();
      req(13'h12bf, 1'b0, 8'h00);
      tick(30);
      chk_fetch(0, vaddr(16'hfff0, 13'h12bf));
      chk_fetch(1, 16'hfff0);
      req(13'h12bf, 1'b1, vbyte(vaddr(16'hfff0, 13'h12bf)));
      req(13'h0000, 1'b1, vbyte(16'hfff0));
      req(13'h0001, 1'b1, vbyte(16'hfff1));

      // Empty buffer, VRAM stalled: underrun without flush, request held steady.
      do_reset(16'h0200, 1'b0);
      tick(3);
      chk("stall_req", {31'h0, vram_req}, 32'h1);
      chk("stall_addr", {16'h0, vram_addr}, 32'h0200);
      chk("stall_underrun0", {31'h0, underrun}, 32'h0);
      flog.delete();
      req(13'h0000, 1'b0, 8'h00);
      chk("underrun_set", {31'h0, underrun}, 32'h1);
      chk("held_req", {31'h0, vram_req}, 32'h1);
      chk("held_addr", {16'h0, vram_addr}, 32'h0200);
      ack_en = 1'b1;
      tick(30);
      chk_fetch(0, 16'h0200);
      req(13'h0000, 1'b1, vbyte(16'h0200));

      // Miss with an in-flight fetch: flush, discard, restart at reg_sad+7.
      req(13'd40, 1'b0, 8'h00);
      tick(30);
      ack_en = 1'b0;
      req(13'd40, 1'b1, vbyte(16'h0200 + 16'd40));
      tick(3);
      flog.delete();
      req(13'd7, 1'b0, 8'h00);
      chk("miss_underrun", {31'h0, underrun}, 32'h1);
      ack_en = 1'b1;
      tick(30);
      chk_fetch(0, 16'h0200 + 16'd48);
      chk_fetch(1, 16'h0207);
      req(13'd7, 1'b1, vbyte(16'h0207));
      req(13'd8, 1'b1, vbyte(16'h0208));

      // VSYNC edge coincides with a hit-valid request: flush wins, underrun untouched.
      do_reset(16'h0300, 1'b1);
      tick(40);
      flog.delete();
      tft_vsync = 1'b0;
      req(13'h0000, 1'b0, 8'h00);
      chk("vs_underrun", {31'h0, underrun}, 32'h0);
      tick(30);
      chk_fetch(0, 16'h0300);
      req(13'h0000, 1'b1, vbyte(16'h0300));
      chk("vs_underrun_after", {31'h0, underrun}, 32'h0);

      // Three underruns, then reset while a fetch is pending.
      do_reset(16'h0400, 1'b0);
      tick(3);
      for (int i = 0; i < 3; i++) req(13'h0000, 1'b0, 8'h00);
`ifdef TFT_FIFO_RESP_UNDERRUN_CNT_EN
      chk("underrun_cnt3", {16'h0, underrun_cnt}, 32'd3);
`endif
      chk("pre_rst_req", {31'h0, vram_req}, 32'h1);
      chk("pre_rst_underrun", {31'h0, underrun}, 32'h1);
      rst = 1'b1;
      tick(1);
      chk_reset("rst_in_req");
      rst = 1'b0;

      tick(3);
      chk("sb_drain", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
